demux_stream_1xn: RTL and testbench

- Registered, parametrised 1-to-N stream demultiplexer with valid/ready handshakes on every port.
- Routes packets from one input stream to one of `N_OUT` output channels.
- The channel is chosen by the first beat's select, and the routing is held for the whole packet (up to `last`).
- Packets with an out-of-range select are discarded, and a saturating drop counter records them.
- Sits between a single producer and per-channel consumers as the sequential generalisation of the fixed 1x2/1x4/1x8 demux family.

---
 rtl/demux_stream_1xn_if.sv | 27 ++
 rtl/demux_stream_1xn.sv | 132 +++++++++++++
 tb/tb_demux_stream_1xn.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/demux_stream_1xn_if.sv
// Stream bundle between one producer and N per-channel consumers of the
// demultiplexer; the DUT takes the slave view, the producer/consumer side the master view.
interface demux_stream_1xn_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = $clog2(N_OUT)
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_last;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_last;

  modport master (
    output in_valid, in_data, in_sel, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/demux_stream_1xn.sv
// Registered 1-to-N packet demultiplexer: the first beat's select locks the
// route until last; packets with an out-of-range select are swallowed and counted.
module demux_stream_1xn #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 8,
  parameter int SEL_W  = $clog2(N_OUT),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  demux_stream_1xn_if.slave bus,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  state_t                  state_q;
  logic [SEL_W-1:0]        chan_q;
  logic [CNT_W-1:0]        drop_q;
  logic                    busy_q;
  logic [N_OUT-1:0]        valid_q;
  logic [N_OUT-1:0]        last_q;
  logic [N_OUT*DATA_W-1:0] data_q;

  logic [SEL_W-1:0] tgt;
  logic [N_OUT-1:0] hit;
  logic [N_OUT-1:0] canAccept;
  logic [N_OUT-1:0] load;
  logic             selLegal;
  logic             tgtReady;
  logic             inReady;
  logic             toBuffer;
  logic             accept;

  assign selLegal  = 32'(bus.in_sel) < N_OUT;
  assign canAccept = ~valid_q | bus.out_ready;

  // In IDLE the live select picks the channel; inside a packet the latched one does.
  always_comb begin
    tgt = (state_q == IDLE) ? bus.in_sel : chan_q;
    hit = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (tgt == SEL_W'(k)) hit[k] = 1'b1;
    end
  end

  assign tgtReady = |(hit & canAccept);

  always_comb begin
    inReady  = 1'b1;
    toBuffer = 1'b0;
    case (state_q)
      IDLE: begin
        if (selLegal) begin
          inReady  = tgtReady;
          toBuffer = 1'b1;
        end
      end
      PKT: begin
        inReady  = tgtReady;
        toBuffer = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = bus.in_valid & inReady;
  assign load   = hit & {N_OUT{accept & toBuffer}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      last_q  <= '0;
      data_q  <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (load[k]) begin
          valid_q[k]                  <= 1'b1;
          last_q[k]                   <= bus.in_last;
          data_q[k*DATA_W +: DATA_W]  <= bus.in_data;
        end else if (bus.out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  // A dropped packet bumps the counter once, on its first beat only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chan_q  <= '0;
      drop_q  <= '0;
      busy_q  <= 1'b0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (selLegal) begin
            chan_q <= bus.in_sel;
            if (!bus.in_last) begin
              state_q <= PKT;
              busy_q  <= 1'b1;
            end
          end else begin
            if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
            if (!bus.in_last) begin
              state_q <= DROP;
              busy_q  <= 1'b1;
            end
          end
        end
        PKT, DROP: begin
          if (bus.in_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.out_data  = data_q;
  assign drop_cnt      = drop_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_demux_stream_1xn.sv
// Scoreboard bench for demux_stream_1xn: an 8-channel instance for routing,
// backpressure and reset; a 6-channel, 2-bit-counter instance for drops.
module tb_demux_stream_1xn;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] dropA;
  logic        busyA;
  logic [1:0]  dropB;
  logic        busyB;

  int compared = 0;
  int mismatched = 0;
  int w, w2, w3;

  logic [8:0] expA[8][$];
  logic [8:0] expB[6][$];

  demux_stream_1xn_if #(.DATA_W(8), .N_OUT(8), .SEL_W(3)) ifA ();
  demux_stream_1xn_if #(.DATA_W(8), .N_OUT(6), .SEL_W(3)) ifB ();

  demux_stream_1xn #(.DATA_W(8), .N_OUT(8), .SEL_W(3), .CNT_W(16)) dutA (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifA),
    .drop_cnt (dropA),
    .busy     (busyA)
  );

  demux_stream_1xn #(.DATA_W(8), .N_OUT(6), .SEL_W(3), .CNT_W(2)) dutB (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifB),
    .drop_cnt (dropB),
    .busy     (busyB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one beat, wait (bounded) for acceptance and record where it must land.
  task automatic applyStimulus(input bit onB, input logic [2:0] sel, input logic [7:0] data,
                               input bit last, input int target, output int waited);
    if (onB) begin
      ifB.in_valid = 1'b1; ifB.in_sel = sel; ifB.in_data = data; ifB.in_last = last;
    end else begin
      ifA.in_valid = 1'b1; ifA.in_sel = sel; ifA.in_data = data; ifA.in_last = last;
    end
    waited = 0;
    @(negedge clk);
    while (!(onB ? ifB.in_ready : ifA.in_ready) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!(onB ? ifB.in_ready : ifA.in_ready)) begin
      checkOutput("inReadyTimeout", 32'(waited), 32'd0);
    end else if (target >= 0) begin
      if (onB) expB[target].push_back({last, data});
      else     expA[target].push_back({last, data});
    end
    @(posedge clk);
    #1;
    if (onB) ifB.in_valid = 1'b0;
    else     ifA.in_valid = 1'b0;
  endtask

  task automatic clearQueues();
    for (int k = 0; k < 8; k++) expA[k].delete();
    for (int k = 0; k < 6; k++) expB[k].delete();
  endtask

  // Every completed output handshake must match the oldest expected beat of its channel.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 8; k++) begin
        if (ifA.out_valid[k] && ifA.out_ready[k]) begin
          if (expA[k].size() == 0) checkOutput($sformatf("A_spurious_ch%0d", k), 32'(ifA.out_valid[k]), 32'd0);
          else checkOutput($sformatf("A_beat_ch%0d", k), 32'({ifA.out_last[k], ifA.out_data[k*8 +: 8]}),
                           32'(expA[k].pop_front()));
        end
      end
      for (int k = 0; k < 6; k++) begin
        if (ifB.out_valid[k] && ifB.out_ready[k]) begin
          if (expB[k].size() == 0) checkOutput($sformatf("B_spurious_ch%0d", k), 32'(ifB.out_valid[k]), 32'd0);
          else checkOutput($sformatf("B_beat_ch%0d", k), 32'({ifB.out_last[k], ifB.out_data[k*8 +: 8]}),
                           32'(expB[k].pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pending;

    // Reset held with random inputs on both instances.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ifA.in_valid = 1'($urandom_range(0, 1)); ifA.in_sel = 3'($urandom_range(0, 7));
      ifA.in_data = 8'($urandom); ifA.in_last = 1'($urandom_range(0, 1)); ifA.out_ready = 8'($urandom);
      ifB.in_valid = 1'($urandom_range(0, 1)); ifB.in_sel = 3'($urandom_range(0, 7));
      ifB.in_data = 8'($urandom); ifB.in_last = 1'($urandom_range(0, 1)); ifB.out_ready = 6'($urandom);
      @(negedge clk);
      checkOutput("rstOutValidA", 32'(ifA.out_valid), 32'd0);
      checkOutput("rstDropA", 32'(dropA), 32'd0);
      checkOutput("rstBusyA", 32'(busyA), 32'd0);
      checkOutput("rstInReadyA", 32'(ifA.in_ready), 32'd1);
      checkOutput("rstInReadyB", 32'(ifB.in_ready), 32'd1);
    end
    ifA.in_valid = 1'b0; ifA.out_ready = '1;
    ifB.in_valid = 1'b0; ifB.out_ready = '1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(1'b0, 3'd3, 8'hA5, 1'b1, 3, w);
    checkOutput("firstValid3", 32'(ifA.out_valid[3]), 32'd1);
    checkOutput("firstData3", 32'(ifA.out_data[3*8 +: 8]), 32'hA5);
    checkOutput("firstLast3", 32'(ifA.out_last[3]), 32'd1);

    // Packet lock: select changes mid-packet must be ignored.
    applyStimulus(1'b0, 3'd5, 8'h10, 1'b0, 5, w);
    checkOutput("lockBusy1", 32'(busyA), 32'd1);
    applyStimulus(1'b0, 3'd2, 8'h11, 1'b0, 5, w);
    checkOutput("lockBusy2", 32'(busyA), 32'd1);
    applyStimulus(1'b0, 3'd2, 8'h12, 1'b0, 5, w);
    checkOutput("lockBusy3", 32'(busyA), 32'd1);
    applyStimulus(1'b0, 3'd2, 8'h13, 1'b1, 5, w);
    checkOutput("lockBusyEnd", 32'(busyA), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure on channel 1.
    ifA.out_ready[1] = 1'b0;
    applyStimulus(1'b0, 3'd1, 8'h21, 1'b0, 1, w);
    fork
      begin
        applyStimulus(1'b0, 3'd1, 8'h22, 1'b0, 1, w2);
        applyStimulus(1'b0, 3'd1, 8'h23, 1'b1, 1, w3);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("bpInReady", 32'(ifA.in_ready), 32'd0);
          checkOutput("bpHeld", 32'({ifA.out_valid[1], ifA.out_data[8 +: 8]}), 32'h121);
        end
        @(posedge clk); #1;
        ifA.out_ready[1] = 1'b1;
      end
    join
    checkOutput("bpWait", 32'(w2), 32'd3);
    checkOutput("bpFlow", 32'(w3), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Illegal select on the 6-channel instance, then a legal single beat.
    applyStimulus(1'b1, 3'd7, 8'hE0, 1'b0, -1, w);
    checkOutput("dropReady0", 32'(w), 32'd0);
    applyStimulus(1'b1, 3'd7, 8'hE1, 1'b0, -1, w);
    checkOutput("dropReady1", 32'(w), 32'd0);
    applyStimulus(1'b1, 3'd0, 8'hE2, 1'b1, -1, w);
    checkOutput("dropReady2", 32'(w), 32'd0);
    checkOutput("dropCnt1", 32'(dropB), 32'd1);
    applyStimulus(1'b1, 3'd0, 8'h55, 1'b1, 0, w);
    checkOutput("legalAfterDrop", 32'(ifB.out_data[7:0]), 32'h55);
    checkOutput("dropCntHeld", 32'(dropB), 32'd1);
    repeat (3) @(posedge clk);
    #1;

    // Saturation of the 2-bit drop counter.
    rst_n = 1'b0;
    clearQueues();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, (i % 2 == 1) ? 3'd6 : 3'd7, 8'(i), 1'b1, -1, w);
      checkOutput($sformatf("satCnt%0d", i), 32'(dropB), (i < 3) ? 32'(i) : 32'd3);
    end

    // Reset in the middle of a packet to channel 4.
    applyStimulus(1'b0, 3'd4, 8'h40, 1'b0, 4, w);
    ifA.in_valid = 1'b1; ifA.in_sel = 3'd4; ifA.in_data = 8'h41; ifA.in_last = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstAsyncValid", 32'(ifA.out_valid), 32'd0);
    checkOutput("rstAsyncBusy", 32'(busyA), 32'd0);
    clearQueues();
    ifA.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 3'd6, 8'h77, 1'b1, 6, w);
    checkOutput("afterRstCh6", 32'({ifA.out_valid[6], ifA.out_data[6*8 +: 8]}), 32'h177);
    checkOutput("afterRstCh4", 32'(ifA.out_valid[4]), 32'd0);
    repeat (5) @(posedge clk);
    #1;

    pending = 0;
    for (int k = 0; k < 8; k++) pending += expA[k].size();
    for (int k = 0; k < 6; k++) pending += expB[k].size();
    checkOutput("drainQueues", 32'(pending), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
